// File: rtl/kd_mode_sequencer.sv
// kd_mode_sequencer: issues the Run_mode step program for one Kyber/Dilithium NTT or INTT, gated by done_flag, with a per-step timeout
module kd_mode_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       kd_sel,
  input  logic       inv,
  input  logic       abort,
  input  logic [1:0] done_flag,
  output logic [3:0] Run_mode,
  output logic       KD_mode,
  output logic       busy,
  output logic       seq_done,
  output logic       seq_err,
  output logic [1:0] err_code,
  output logic [1:0] step_idx
);
  typedef enum logic [1:0] {IDLE, ARM, WAIT, FINISH} state_t;
  state_t state;
  logic inv_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0] exp_flag;
  logic last, tmo;
  function automatic logic [3:0] prog_code(input logic k, input logic i, input logic [1:0] s);
    return k ? (i ? 4'd11 : 4'd5) + {3'd0, s[0]}
             : i ? (s[1] ? 4'd7 : 4'd9) + {3'd0, s[0]} : {2'd0, s} + 4'd1;
  endfunction
  // Per-step decode: which completion code is expected, whether this is the final step, and timeout hit
  always_comb begin
    exp_flag = Run_mode[0] ? 2'b01 : 2'b10;
    last = KD_mode ? step_idx[0] : &step_idx;
    tmo = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  end
  // Sequencer FSM; a nonzero flag in ARM is a leftover from the previous step and is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Run_mode <= 4'd0;
      KD_mode <= 1'b0;
      inv_q <= 1'b0;
      busy <= 1'b0;
      seq_done <= 1'b0;
      seq_err <= 1'b0;
      err_code <= 2'b00;
      step_idx <= 2'd0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= ARM;
        KD_mode <= kd_sel;
        inv_q <= inv;
        step_idx <= 2'd0;
        Run_mode <= prog_code(kd_sel, inv, 2'd0);
        busy <= 1'b1;
        seq_err <= 1'b0;
        err_code <= 2'b00;
        cnt <= '0;
      end
    end else if (abort) begin
      state <= IDLE;
      Run_mode <= 4'd0;
      busy <= 1'b0;
      seq_done <= 1'b0;
    end else if (state == FINISH) begin
      state <= IDLE;
      busy <= 1'b0;
      seq_done <= 1'b0;
    end else if (state == WAIT && done_flag == exp_flag) begin
      cnt <= '0;
      if (last) begin
        state <= FINISH;
        Run_mode <= 4'd0;
        seq_done <= 1'b1;
      end else begin
        state <= ARM;
        step_idx <= step_idx + 2'd1;
        Run_mode <= prog_code(KD_mode, inv_q, step_idx + 2'd1);
      end
    end else if ((state == WAIT && done_flag != 2'b00) || tmo) begin
      state <= IDLE;
      Run_mode <= 4'd0;
      busy <= 1'b0;
      seq_err <= 1'b1;
      err_code <= (state == WAIT && done_flag != 2'b00) ? 2'b10 : 2'b01;
    end else begin
      cnt <= cnt + 1'b1;
      if (state == ARM && done_flag == 2'b00) state <= WAIT;
    end
  end
endmodule

// File: tb/tb_kd_mode_sequencer.sv
// tb_kd_mode_sequencer: directed self-checking bench for kd_mode_sequencer
module tb_kd_mode_sequencer;
  logic clk = 1'b0;
  logic rst, start, kd_sel, inv, abort;
  logic [1:0] done_flag;
  logic [3:0] Run_mode;
  logic KD_mode, busy, seq_done, seq_err;
  logic [1:0] err_code, step_idx;
  int errors = 0;
  int checks = 0;
  kd_mode_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .kd_sel(kd_sel), .inv(inv), .abort(abort),
    .done_flag(done_flag), .Run_mode(Run_mode), .KD_mode(KD_mode), .busy(busy),
    .seq_done(seq_done), .seq_err(seq_err), .err_code(err_code), .step_idx(step_idx)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_step(input int n, input logic [1:0] code, input logic [3:0] nxt, input string tag);
    done_flag = 2'b00;
    repeat (n) tick();
    done_flag = code;
    tick();
    done_flag = 2'b00;
    chk(tag, {28'd0, Run_mode}, {28'd0, nxt});
  endtask
  task automatic go(input logic k, input logic i);
    start = 1'b1;
    kd_sel = k;
    inv = i;
    tick();
    start = 1'b0;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_run"}, {28'd0, Run_mode}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, seq_done}, 32'd0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; kd_sel = 1'b0; inv = 1'b0; abort = 1'b0; done_flag = 2'b00;
    tick(); tick();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset_err", {31'd0, seq_err}, 32'd0);
    chk("reset_code", {30'd0, err_code}, 32'd0);
    chk("reset_step", {30'd0, step_idx}, 32'd0);
    chk("reset_kd", {31'd0, KD_mode}, 32'd0);
    // Kyber forward: 1,2,3,4 then FINISH
    go(1'b0, 1'b0);
    chk("kf_first", {28'd0, Run_mode}, 32'd1);
    chk("kf_busy", {31'd0, busy}, 32'd1);
    do_step(29, 2'b01, 4'd2, "kf_s0");
    chk("kf_step1", {30'd0, step_idx}, 32'd1);
    do_step(13, 2'b10, 4'd3, "kf_s1");
    do_step(29, 2'b01, 4'd4, "kf_s2");
    chk("kf_step3", {30'd0, step_idx}, 32'd3);
    do_step(13, 2'b10, 4'd0, "kf_s3");
    chk("kf_pulse", {31'd0, seq_done}, 32'd1);
    chk("kf_busy_fin", {31'd0, busy}, 32'd1);
    tick();
    chk_idle("kf_end");
    chk("kf_err", {31'd0, seq_err}, 32'd0);
    // Dilithium inverse: 11,12; start mid-run ignored
    go(1'b1, 1'b1);
    chk("di_first", {28'd0, Run_mode}, 32'd11);
    chk("di_kd", {31'd0, KD_mode}, 32'd1);
    chk("di_step0", {30'd0, step_idx}, 32'd0);
    tick();
    go(1'b0, 1'b0);
    chk("di_start_ign", {28'd0, Run_mode}, 32'd11);
    chk("di_kd_ign", {31'd0, KD_mode}, 32'd1);
    do_step(3, 2'b01, 4'd12, "di_s0");
    chk("di_step1", {30'd0, step_idx}, 32'd1);
    chk("di_kd1", {31'd0, KD_mode}, 32'd1);
    do_step(3, 2'b10, 4'd0, "di_s1");
    chk("di_pulse", {31'd0, seq_done}, 32'd1);
    tick();
    chk_idle("di_end");
    // Stale flag held across the 1->2 transition
    go(1'b0, 1'b0);
    tick();
    done_flag = 2'b01;
    tick();
    chk("st_acc", {28'd0, Run_mode}, 32'd2);
    tick(); tick(); tick();
    chk("st_hold", {28'd0, Run_mode}, 32'd2);
    chk("st_noerr", {31'd0, seq_err}, 32'd0);
    done_flag = 2'b10;
    tick();
    chk("st_arm_ign", {28'd0, Run_mode}, 32'd2);
    done_flag = 2'b00;
    tick();
    chk("st_rearm", {28'd0, Run_mode}, 32'd2);
    done_flag = 2'b10;
    tick();
    done_flag = 2'b00;
    chk("st_fresh", {28'd0, Run_mode}, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("st_abort");
    chk("st_abort_err", {31'd0, seq_err}, 32'd0);
    // Timeout after 64 cycles in step 0
    go(1'b1, 1'b0);
    chk("to_first", {28'd0, Run_mode}, 32'd5);
    repeat (63) tick();
    chk("to_edge_m1", {31'd0, seq_err}, 32'd0);
    chk("to_edge_run", {28'd0, Run_mode}, 32'd5);
    tick();
    chk("to_err", {31'd0, seq_err}, 32'd1);
    chk("to_code", {30'd0, err_code}, 32'd1);
    chk_idle("to_end");
    // Bad flag in step 1, then clean rerun
    go(1'b0, 1'b0);
    chk("bf_clr", {31'd0, seq_err}, 32'd0);
    chk("bf_clr_code", {30'd0, err_code}, 32'd0);
    do_step(3, 2'b01, 4'd2, "bf_s0");
    tick();
    done_flag = 2'b01;
    tick();
    done_flag = 2'b00;
    chk("bf_err", {31'd0, seq_err}, 32'd1);
    chk("bf_code", {30'd0, err_code}, 32'd2);
    chk_idle("bf_end");
    go(1'b0, 1'b0);
    chk("bf2_clr", {31'd0, seq_err}, 32'd0);
    do_step(2, 2'b01, 4'd2, "bf2_s0");
    do_step(2, 2'b10, 4'd3, "bf2_s1");
    do_step(2, 2'b01, 4'd4, "bf2_s2");
    do_step(2, 2'b10, 4'd0, "bf2_s3");
    chk("bf2_pulse", {31'd0, seq_done}, 32'd1);
    tick();
    chk("bf2_err", {31'd0, seq_err}, 32'd0);
    // Reset mid-step 3 with abort and completion on the same edge
    go(1'b0, 1'b0);
    do_step(2, 2'b01, 4'd2, "rs_s0");
    do_step(2, 2'b10, 4'd3, "rs_s1");
    do_step(2, 2'b01, 4'd4, "rs_s2");
    tick();
    rst = 1'b1; abort = 1'b1; done_flag = 2'b10;
    tick();
    rst = 1'b0; abort = 1'b0; done_flag = 2'b00;
    chk_idle("rs");
    chk("rs_err", {31'd0, seq_err}, 32'd0);
    chk("rs_step", {30'd0, step_idx}, 32'd0);
    // Abort alone beats completion
    go(1'b0, 1'b0);
    do_step(2, 2'b01, 4'd2, "ab_s0");
    do_step(2, 2'b10, 4'd3, "ab_s1");
    do_step(2, 2'b01, 4'd4, "ab_s2");
    tick();
    abort = 1'b1; done_flag = 2'b10;
    tick();
    abort = 1'b0; done_flag = 2'b00;
    chk_idle("ab");
    chk("ab_err", {31'd0, seq_err}, 32'd0);
    tick();
    chk("ab_nopulse", {31'd0, seq_done}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kd_mode_sequencer.md
# kd_mode_sequencer

Hardware replacement for the hand-timed `Run_mode` stimulus that currently drives `KD_top`. On a `start` request, the block issues the full `Run_mode` step sequence for one Kyber or Dilithium NTT/INTT transform. It advances each step only on the `done_flag` completion code returned by `KD_top`, and enforces a per-step timeout. It sits directly in front of `KD_top`, owning the `Run_mode` and `KD_mode` inputs.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: maximum cycles allowed in any one step before abort with error. Must be ≥ 2.
- `CNT_W`, default 13: timeout counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk` in 1: the only clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `kd_sel` in 1: 0 = Kyber, 1 = Dilithium. Sampled with `start`.
- `inv` in 1: 0 = forward NTT, 1 = inverse NTT. Sampled with `start`.
- `abort` in 1: synchronous cancel of the sequence in progress.
- `done_flag` in 2: completion code from `KD_top`.
  - 2'b00: busy.
  - 2'b01: compute phase finished.
  - 2'b10: done phase finished.
  - 2'b11: illegal.
- `Run_mode` out 4: step code to `KD_top`.
- `KD_mode` out 1: latched `kd_sel`.
- `busy` out 1: sequence in progress.
- `seq_done` out 1: one-cycle pulse when the final step completes.
- `seq_err` out 1: sticky error flag. Cleared by `rst` or an accepted `start`.
- `err_code` out 2: 01 = timeout, 10 = bad flag. Valid while `seq_err` is 1.
- `step_idx` out 2: index of the current step within the program.

## Operation
- Run_mode codes:
  - 0 IDLE.
  - 1 K_2_NTT, 2 Done_K_2_NTT.
  - 3 K_4_NTT, 4 Done_K_4_NTT.
  - 5 D_2_NTT, 6 Done_D_2_NTT.
  - 7 K_2_INTT, 8 Done_K_2_INTT.
  - 9 K_4_INTT, 10 Done_K_4_INTT.
  - 11 D_2_INTT, 12 Done_D_2_INTT.
- Programs, selected by {kd_sel, inv}:
  - 00 (Kyber forward): 1, 2, 3, 4.
  - 01 (Kyber inverse): 9, 10, 7, 8.
  - 10 (Dilithium forward): 5, 6.
  - 11 (Dilithium inverse): 11, 12.
- Expected code per step:
  - Odd Run_mode (compute step) expects 2'b01.
  - Even, non-zero Run_mode (done step) expects 2'b10.
- FSM states: IDLE, ARM, WAIT, FINISH.
  - IDLE: `start`=1 latches `kd_sel`/`inv`, sets step 0, clears `seq_err`/`err_code`, goes to ARM.
  - ARM: waits for `done_flag`==00 sampled on one cycle, which discards stale flags from the previous step, then goes to WAIT. The timeout counter runs during ARM.
  - WAIT:
    - `done_flag` equal to the expected code: if this is the last step, go to FINISH; otherwise step+1 and go to ARM.
    - `done_flag` equal to the other non-zero code, or 11: error "bad flag".
    - 00: keep waiting.
  - FINISH: lasts one cycle with `seq_done`=1, then returns to IDLE.
- Timeout:
  - The counter clears on every step entry and increments every cycle in ARM/WAIT.
  - When the counter reaches TIMEOUT_CYCLES-1 without acceptance, the block sets `seq_err`=1, `err_code`=01, and returns to IDLE.
- Error handling, for both timeout and bad flag: `Run_mode`→0, `busy`→0, no `seq_done`.
- `abort` in ARM/WAIT/FINISH: return to IDLE, `Run_mode`=0, no `seq_done`, no error. Ignored in IDLE.
- `start` while not IDLE: ignored.

## Timing
- Reset values, effective at the edge after `rst`=1: state IDLE, `Run_mode`=0, `KD_mode`=0, `busy`=0, `seq_done`=0, `seq_err`=0, `err_code`=0, `step_idx`=0, counter=0. Reset mid-sequence has the same effect.
- All outputs are registered.
- `start` sampled at edge N gives, after edge N: `Run_mode`=first code, `busy`=1, `KD_mode`=`kd_sel`.
- Completion code sampled in WAIT at edge M gives, after edge M:
  - Intermediate step: next `Run_mode` and `step_idx`+1.
  - Last step: `Run_mode`=0, `seq_done`=1, `busy`=1; then after edge M+1, `busy`=0 and `seq_done`=0.
- Minimum step length is 2 cycles: one cycle in ARM plus one in WAIT.
- Simultaneous events on the same edge, in priority order: `rst` > `abort` > acceptance > bad flag > timeout.
- `Run_mode` is stable for the whole of each step; it changes only on step transitions.

## Test plan
- Kyber forward: `start` with kd_sel=0, inv=0; a model returns 01 after 30 cycles and 10 after 14 cycles per step → Run_mode sequence 1, 2, 3, 4, 0; one `seq_done` pulse; `seq_err`=0.
- Dilithium inverse: kd_sel=1, inv=1 → Run_mode 11, 12, 0; `KD_mode`=1 throughout; `step_idx` goes 0, 1.
- Stale flag: `done_flag` is held at 01 across the 1→2 transition and only then returns to 00 → step 2 is not accepted until a fresh 10 arrives.
- Timeout: TIMEOUT_CYCLES=64, `done_flag` is never asserted → after 64 cycles in step 0: `seq_err`=1, `err_code`=01, `Run_mode`=0, no `seq_done`.
- Bad flag: in step 1 (Run_mode 2), `done_flag`=01 → `err_code`=10, IDLE. A following `start` clears `seq_err` and the sequence then runs cleanly.
- `rst` asserted mid-step 3, with a simultaneous `abort` and completion on one edge → all outputs return to their reset values; in a separate run, `abort` alone beats the completion (Run_mode=0, no pulse).
